// File: rtl/reg_wb_arbiter_pkg.sv
// Shared processor definitions for the register-file writeback path.
// Holds the architectural widths and the write-request record used by the arbiter.
package reg_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/reg_wb_arbiter_wb_fifo.sv
// In-order buffer for multi-cycle results awaiting a register-file write slot.
// Also reports which registers are targeted by stored entries behind the head.
module wb_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [REG_ADDR_W-1:0]         push_addr_i,
  input  logic [XLEN-1:0]               push_data_i,
  output logic [REG_ADDR_W-1:0]         head_addr_o,
  output logic [XLEN-1:0]               head_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic [(1<<REG_ADDR_W)-1:0]    behind_mask_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [REG_ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [XLEN-1:0]       data_mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full_o      = (cnt_q == CNT_W'(DEPTH));
  assign empty_o     = (cnt_q == {CNT_W{1'b0}});
  assign count_o     = cnt_q;
  assign head_addr_o = addr_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];
  assign push_ok_s   = push_i & ~full_o;
  assign pop_ok_s    = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Entries behind the head decide whether a head grant may clear its busy bit.
  always_comb begin
    behind_mask_o = {(1<<REG_ADDR_W){1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      if (i < int'(cnt_q)) begin
        behind_mask_o[addr_mem_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
      end else begin
        behind_mask_o = behind_mask_o;
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Single write port arbiter between the in-order pipeline and buffered multi-cycle results.
// Pipeline wins by default; a starvation counter forces the buffer head through via stall_pipe.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wb_valid,
  input  logic [REG_ADDR_W-1:0] pipe_wb_addr,
  input  logic [XLEN-1:0]       pipe_wb_data,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_addr,
  input  logic [XLEN-1:0]       mc_data,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] write_port_addr,
  output logic [XLEN-1:0]       write_data,
  output logic [31:0]           busy,
  output logic                  stall_pipe
);

  localparam int          CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0]  LIMIT_C = 4'(STARVE_LIMIT);

  logic                  push_s;
  logic                  pipe_req_s;
  logic                  head_grant_s;
  logic                  full_s;
  logic                  empty_s;
  logic [CNT_W-1:0]      count_s;
  logic [REG_ADDR_W-1:0] head_addr_s;
  logic [XLEN-1:0]       head_data_s;
  logic [31:0]           behind_s;

  wb_req_t     wr_q, wr_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  starve_q, starve_d;
  logic        stall_q, stall_d;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (push_s),
    .pop_i         (head_grant_s),
    .push_addr_i   (mc_addr),
    .push_data_i   (mc_data),
    .head_addr_o   (head_addr_s),
    .head_data_o   (head_data_s),
    .full_o        (full_s),
    .empty_o       (empty_s),
    .count_o       (count_s),
    .behind_mask_o (behind_s)
  );

  assign mc_ready        = ~full_s;
  assign write_en        = wr_q.valid;
  assign write_port_addr = wr_q.addr;
  assign write_data      = wr_q.data;
  assign busy            = busy_q;
  assign stall_pipe      = stall_q;

  // Writes to r0 are dropped on both sides; a stalled pipeline request is ignored.
  always_comb begin
    push_s       = mc_valid & ~full_s & (mc_addr != 5'd0);
    pipe_req_s   = pipe_wb_valid & ~stall_q & (pipe_wb_addr != 5'd0);
    head_grant_s = ~empty_s & ~pipe_req_s;
  end

  always_comb begin
    wr_d       = wr_q;
    wr_d.valid = 1'b0;
    if (pipe_req_s) begin
      wr_d.valid = 1'b1;
      wr_d.addr  = pipe_wb_addr;
      wr_d.data  = pipe_wb_data;
    end else if (head_grant_s) begin
      wr_d.valid = 1'b1;
      wr_d.addr  = head_addr_s;
      wr_d.data  = head_data_s;
    end else begin
      wr_d.valid = 1'b0;
    end
  end

  // Set after clear so a same-cycle push to the granted register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (head_grant_s && !behind_s[head_addr_s]) begin
      busy_d[head_addr_s] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (push_s) begin
      busy_d[mc_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (count_s == {CNT_W{1'b0}} || head_grant_s) begin
      starve_d = 4'd0;
    end else if (starve_q < LIMIT_C) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = LIMIT_C;
    end
    if (empty_s || head_grant_s) begin
      stall_d = 1'b0;
    end else if (starve_q == LIMIT_C) begin
      stall_d = 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= '0;
      busy_q   <= 32'd0;
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with default parameters (FIFO_DEPTH 2, STARVE_LIMIT 4).
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_addr;
  logic [31:0] pipe_wb_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        write_en;
  logic [4:0]  write_port_addr;
  logic [31:0] write_data;
  logic [31:0] busy;
  logic        stall_pipe;

  int n_chk  = 0;
  int n_pass = 0;

  reg_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_wb_valid   (pipe_wb_valid),
    .pipe_wb_addr    (pipe_wb_addr),
    .pipe_wb_data    (pipe_wb_data),
    .mc_valid        (mc_valid),
    .mc_ready        (mc_ready),
    .mc_addr         (mc_addr),
    .mc_data         (mc_data),
    .write_en        (write_en),
    .write_port_addr (write_port_addr),
    .write_data      (write_data),
    .busy            (busy),
    .stall_pipe      (stall_pipe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
    pipe_wb_valid = v;
    pipe_wb_addr  = a;
    pipe_wb_data  = d;
  endtask

  task automatic mc(input logic v, input logic [4:0] a, input logic [31:0] d);
    mc_valid = v;
    mc_addr  = a;
    mc_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'd0);
    mc(1'b0, 5'd0, 32'd0);
    step();
    step();
    chk("rst_we", write_en, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_stall", stall_pipe, 32'd0);
    rst = 1'b0;
    step();
    chk("rel_ready", mc_ready, 32'd1);
    chk("rel_addr", write_port_addr, 32'd0);
    chk("rel_data", write_data, 32'd0);

    // Pipeline write appears one cycle later
    pipe(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    pipe(1'b0, 5'd0, 32'd0);
    chk("p_we", write_en, 32'd1);
    chk("p_addr", write_port_addr, 32'd5);
    chk("p_data", write_data, 32'hDEADBEEF);
    step();
    chk("p_we_lo", write_en, 32'd0);

    // Multi-cycle result through an empty FIFO
    mc(1'b1, 5'd7, 32'h11);
    step();
    mc(1'b0, 5'd0, 32'd0);
    chk("mc_busy7_set", busy[7], 32'd1);
    chk("mc_no_bypass", write_en, 32'd0);
    step();
    chk("mc_we", write_en, 32'd1);
    chk("mc_addr", write_port_addr, 32'd7);
    chk("mc_data", write_data, 32'h11);
    step();
    chk("mc_busy7_clr", busy[7], 32'd0);
    chk("mc_we_lo", write_en, 32'd0);

    // Pipe addr 0 frees the slot for a pending head
    pipe(1'b1, 5'd1, 32'hA);
    mc(1'b1, 5'd3, 32'h33);
    step();
    mc(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd0, 32'hBAD);
    chk("z_pipe_addr", write_port_addr, 32'd1);
    step();
    pipe(1'b0, 5'd0, 32'd0);
    chk("z_head_we", write_en, 32'd1);
    chk("z_head_addr", write_port_addr, 32'd3);
    chk("z_head_data", write_data, 32'h33);
    mc(1'b1, 5'd0, 32'h55);
    step();
    mc(1'b0, 5'd0, 32'd0);
    chk("z_mc0_busy", busy, 32'd0);
    step();
    chk("z_mc0_we", write_en, 32'd0);

    // Two entries to the same register
    pipe(1'b1, 5'd2, 32'h1);
    mc(1'b1, 5'd9, 32'h91);
    step();
    mc(1'b1, 5'd9, 32'h92);
    step();
    pipe(1'b0, 5'd0, 32'd0);
    mc(1'b0, 5'd0, 32'd0);
    chk("d_ready_full", mc_ready, 32'd0);
    chk("d_busy9", busy[9], 32'd1);
    step();
    chk("d_first", write_data, 32'h91);
    chk("d_busy9_hold", busy[9], 32'd1);
    chk("d_ready_back", mc_ready, 32'd1);
    step();
    chk("d_second", write_data, 32'h92);
    chk("d_busy9_clr", busy[9], 32'd0);
    step();

    // Starvation with the pipeline writing every cycle
    pipe(1'b1, 5'd4, 32'h40);
    mc(1'b1, 5'd10, 32'hA1);
    step();
    mc(1'b1, 5'd11, 32'hA2);
    step();
    mc(1'b0, 5'd0, 32'd0);
    chk("s_ready_full", mc_ready, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s_nostall%0d", k), stall_pipe, 32'd0);
      step();
    end
    chk("s_stall", stall_pipe, 32'd1);
    chk("s_pipe_wr", write_port_addr, 32'd4);
    pipe(1'b1, 5'd6, 32'hEE);
    step();
    pipe(1'b0, 5'd0, 32'd0);
    chk("s_head1_addr", write_port_addr, 32'd10);
    chk("s_head1_data", write_data, 32'hA1);
    chk("s_stall_lo", stall_pipe, 32'd0);
    step();
    chk("s_head2_we", write_en, 32'd1);
    chk("s_head2_addr", write_port_addr, 32'd11);
    chk("s_head2_data", write_data, 32'hA2);
    chk("s_busy_clr", busy, 32'd0);
    step();

    // Reset with two buffered entries
    pipe(1'b1, 5'd2, 32'h2);
    mc(1'b1, 5'd12, 32'hC);
    step();
    mc(1'b1, 5'd13, 32'hD);
    step();
    chk("r_busy_pre", busy, 32'h0000_3000);
    pipe(1'b0, 5'd0, 32'd0);
    mc(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    #1;
    chk("r_busy_async", busy, 32'd0);
    chk("r_we_async", write_en, 32'd0);
    step();
    chk("r_we_hold", write_en, 32'd0);
    rst = 1'b0;
    step();
    chk("r_we_rel", write_en, 32'd0);
    chk("r_ready_rel", mc_ready, 32'd1);
    chk("r_busy_rel", busy, 32'd0);
    step();
    chk("r_no_stale", write_en, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
